serial_subtractor16: RTL and testbench
======================================

Name: serial_subtractor16

Overview:
- Bit-serial 16-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock through a single full-subtractor cell.
- Inverse-direction companion to the team's parallel 16-bit ripple adder.
- Used as an area-cheap datapath element and as a cross-check for the adder: a + b + cin fed back through this block must recover a.
- Start/busy/done handshake toward a sequencing controller.

Parameters:
WIDTH, 16, operand and result width in bits. Data buses are indexed [WIDTH:1], with bit 1 as the LSB.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend, [WIDTH:1]
b  input  WIDTH  subtrahend, [WIDTH:1]
bin  input  1  borrow-in
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse; diff and bout valid
diff  output  WIDTH  result, [WIDTH:1]
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)

Behaviour:
- One clock domain. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state IDLE, bit counter 0.
  - busy=0, done=0, diff=0, bout=0.
  - Internal operand/borrow registers cleared.
- Reset during RUN aborts the operation: no done pulse, outputs go to their reset values.
- States:
  - IDLE: busy=0. On an edge with start=1, latch a, b, bin into shift registers, clear the counter, go to RUN.
  - RUN: busy=1. Each edge:
    - bit cell takes opA[1], opB[1] and the borrow register.
    - d = x ^ y ^ br; br_next = (~x & y) | (~(x ^ y) & br).
    - Shift d into the result register MSB-first (right shift), shift both operands right by 1, increment the counter.
    - On the edge where the counter reaches WIDTH: go to IDLE, load diff and bout from the result and final borrow, set done=1.
- done is high for exactly one cycle, in the cycle after the last shift edge.
- Latency: start sampled at edge E gives done=1 and valid outputs during the cycle following edge E+WIDTH (17 edges total for WIDTH=16).
- Throughput: one result every WIDTH+1 cycles, with start held high continuously.
- diff and bout hold their value from done until the next done or reset. They do not change during a new RUN.
- start while busy=1: ignored, operands not re-latched.
- start in the same cycle done=1: accepted, since the state is already IDLE. The new RUN begins and the old diff is held.
- a, b, bin may change freely after the start edge.
- Arithmetic is modulo 2^WIDTH:
  - bin=1 with a=b gives diff = all ones and bout=1.
  - The all-ones minus all-ones case is legal.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - Extra output port ovf (1 bit), registered alongside diff.
  - ovf = (a[WIDTH] != b[WIDTH]) && (diff[WIDTH] != a[WIDTH]), i.e. two's-complement signed overflow.
  - The latched operand MSBs are captured at start.
  - ovf resets to 0 and holds with diff.
- Undefined: no ovf port and no extra registers. All other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - WIDTH default constant.
  - counter width CNT_W = $clog2(WIDTH+1).
  - state encoding IDLE=1'b0, RUN=1'b1.
- Sub-module full_sub1: combinational one-bit full subtractor (x, y, br_in -> d, br_out). It is instantiated once and is also unit-testable standalone.

Test Plan:
- Reset, then a=0x0000, b=0x0000, bin=0, start pulse -> busy high for 16 cycles; done at edge+17; diff=0x0000, bout=0.
- a=0x0820, b=0x1083, bin=1 -> diff=0xF79C, bout=1. Separately, a=0xC1E0, b=0x641F, bin=0 -> diff=0x5DC1, bout=0.
- a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1. Then a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, and ovf=1 when SERIAL_SUB_OVERFLOW_EN is defined.
- During RUN of 0x0005-0x0003, drive start=1 with a=0x1234 -> ignored; done yields diff=0x0002, bout=0. Back-to-back start held high -> second done exactly 17 cycles after the first.
- rst_n=0 at shift 8 of 0x00FF-0x0001 -> next cycle busy=0, done=0, diff=0, bout=0, and no later done. A fresh start then completes normally with diff=0x00FE.
- Cross-check loop: for 1000 random (a,b,cin), compute s = a + b + cin with the 16-bit adder, then run s - b - cin -> diff == a every time.

Source files
------------

// File: rtl/serial_subtractor16_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 16;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_subtractor16_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// SERIAL_SUB_OVERFLOW_EN adds the signed-overflow flag ovf.
interface serial_subtractor16_if #(
  parameter int WIDTH = serial_sub_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH:1]   a;
  logic [WIDTH:1]   b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH:1]   diff;
  logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_subtractor16_full_sub1.sv
// One-bit full subtractor cell: d = x - y - br_in, br_out is the borrow.
module full_sub1 (
  input  logic x,
  input  logic y,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = x ^ y ^ br_in;
  assign br_out = (~x & y) | (~(x ^ y) & br_in);

endmodule

// File: rtl/serial_subtractor16.sv
// Bit-serial diff = a - b - bin, LSB first through a single full_sub1 cell.
// SERIAL_SUB_OVERFLOW_EN adds a registered two's-complement overflow flag.
module serial_subtractor16
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor16_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [WIDTH:1] opa_reg, opa_next;
  logic [WIDTH:1] opb_reg, opb_next;
  // Only WIDTH-1 bits are ever parked here; the final bit goes straight to diff.
  logic [WIDTH:2] res_reg, res_next;
  logic [WIDTH:1] diff_reg, diff_next;
  logic           br_reg, br_next;
  logic           bout_reg, bout_next;
  logic           done_reg, done_next;
  logic           cell_d, cell_br;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic           amsb_reg, amsb_next;
  logic           bmsb_reg, bmsb_next;
  logic           ovf_reg, ovf_next;
`endif

  full_sub1 u_cell (
    .x      (opa_reg[1]),
    .y      (opb_reg[1]),
    .br_in  (br_reg),
    .d      (cell_d),
    .br_out (cell_br)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    res_next   = res_reg;
    diff_next  = diff_reg;
    br_next    = br_reg;
    bout_next  = bout_reg;
    done_next  = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    amsb_next  = amsb_reg;
    bmsb_next  = bmsb_reg;
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          opa_next   = bus.a;
          opb_next   = bus.b;
          br_next    = bus.bin;
          cnt_next   = '0;
          res_next   = '0;
          state_next = RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
          amsb_next  = bus.a[WIDTH];
          bmsb_next  = bus.b[WIDTH];
`endif
        end
      end
      RUN: begin
        res_next = {cell_d, res_reg[WIDTH:3]};
        opa_next = {1'b0, opa_reg[WIDTH:2]};
        opb_next = {1'b0, opb_reg[WIDTH:2]};
        br_next  = cell_br;
        cnt_next = cnt_reg + 1'b1;
        // Last bit: publish the result; diff stays frozen through later runs.
        if (cnt_reg == LAST) begin
          state_next = IDLE;
          diff_next  = {cell_d, res_reg};
          bout_next  = cell_br;
          done_next  = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_next   = (amsb_reg != bmsb_reg) && (cell_d != amsb_reg);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
      diff_reg  <= '0;
      br_reg    <= 1'b0;
      bout_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_reg  <= 1'b0;
      bmsb_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      res_reg   <= res_next;
      diff_reg  <= diff_next;
      br_reg    <= br_next;
      bout_reg  <= bout_next;
      done_reg  <= done_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_reg  <= amsb_next;
      bmsb_reg  <= bmsb_next;
      ovf_reg   <= ovf_next;
`endif
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor16.sv
// Randomised bench for serial_subtractor16 against an integer-arithmetic model.
module tb_serial_subtractor16;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor16_if #(.WIDTH(W)) sif ();

  serial_subtractor16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {bout, diff} from plain signed integer arithmetic.
  function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return {(r < 0), 16'(r)};
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d);
    return (x[15] != y[15]) && (d[15] != x[15]);
  endfunction

  task automatic wait_done(input int max_edges, output int edges, output bit seen);
    seen = 1'b0;
    edges = 0;
    while (!seen && edges < max_edges) begin
      @(posedge clk); #1;
      edges++;
      if (sif.done) seen = 1'b1;
    end
    if (!seen) check_eq("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_result(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] e;
    e = ref_sub(x, y, c);
    check_eq({tag, "_diff"}, 32'(sif.diff), 32'(e[15:0]));
    check_eq({tag, "_bout"}, 32'(sif.bout), 32'(e[16]));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check_eq({tag, "_ovf"}, 32'(sif.ovf), 32'(ref_ovf(x, y, e[15:0])));
`endif
    $display("txn %s a=%h b=%h bin=%b -> diff=%h bout=%b", tag, x, y, c, sif.diff, sif.bout);
  endtask

  // Full transaction from IDLE; operands are scrambled right after the start edge.
  task automatic run_sub(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c,
                         output logic [15:0] d, output logic bo);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    sif.start = 1'b1; sif.a = x; sif.b = y; sif.bin = c;
    @(posedge clk); #1;
    sif.start = 1'b0;
    sif.a = 16'($urandom); sif.b = 16'($urandom); sif.bin = 1'($urandom);
    busy_cnt = int'(sif.busy);
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (sif.done) seen = 1'b1;
      else busy_cnt += int'(sif.busy);
    end
    d = sif.diff;
    bo = sif.bout;
    if (!seen) begin
      check_eq({tag, "_timeout"}, 32'(0), 32'(1));
    end else begin
      check_eq({tag, "_latency"}, 32'(lat), 32'(16));
      check_eq({tag, "_busycyc"}, 32'(busy_cnt), 32'(16));
      check_result(tag, x, y, c);
      @(posedge clk); #1;
      check_eq({tag, "_donepulse"}, 32'(sif.done), 32'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        bo;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] sum;
    int          edges;
    int          dcount;
    bit          seen;

    sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(sif.busy), 32'(0));
    check_eq("rst_done", 32'(sif.done), 32'(0));
    check_eq("rst_diff", 32'(sif.diff), 32'(0));
    check_eq("rst_bout", 32'(sif.bout), 32'(0));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check_eq("rst_ovf", 32'(sif.ovf), 32'(0));
`endif
    rst_n = 1'b1;

    run_sub("zero", 16'h0000, 16'h0000, 1'b0, d, bo);
    run_sub("v1", 16'h0820, 16'h1083, 1'b1, d, bo);
    run_sub("v2", 16'hC1E0, 16'h641F, 1'b0, d, bo);
    run_sub("ones", 16'hFFFF, 16'hFFFF, 1'b1, d, bo);
    run_sub("minneg", 16'h8000, 16'h0001, 1'b0, d, bo);
    run_sub("eqbin", 16'h1234, 16'h1234, 1'b1, d, bo);
    run_sub("onesnb", 16'hFFFF, 16'hFFFF, 1'b0, d, bo);

    // start while busy must be ignored
    @(negedge clk);
    sif.start = 1'b1; sif.a = 16'h0005; sif.b = 16'h0003; sif.bin = 1'b0;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sif.start = 1'b1; sif.a = 16'h1234; sif.b = 16'h0001; sif.bin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    sif.start = 1'b0;
    wait_done(40, edges, seen);
    if (seen) begin
      check_eq("ign_latency", 32'(edges + 8), 32'(16));
      check_result("ignore", 16'h0005, 16'h0003, 1'b0);
    end
    @(posedge clk); #1;
    check_eq("ign_idle", 32'(sif.busy), 32'(0));

    // back-to-back with start held high
    @(negedge clk);
    sif.start = 1'b1; sif.a = 16'h4321; sif.b = 16'h1111; sif.bin = 1'b1;
    @(posedge clk); #1;
    sif.a = 16'h0100; sif.b = 16'h0200; sif.bin = 1'b0;
    wait_done(40, edges, seen);
    if (seen) check_result("b2b_first", 16'h4321, 16'h1111, 1'b1);
    @(posedge clk); #1;
    sif.start = 1'b0;
    check_eq("b2b_restart_busy", 32'(sif.busy), 32'(1));
    check_eq("b2b_restart_done", 32'(sif.done), 32'(0));
    check_eq("b2b_diff_hold", 32'(sif.diff), 32'(16'h3210 - 16'h0001));
    wait_done(40, edges, seen);
    if (seen) begin
      check_eq("b2b_gap", 32'(edges + 1), 32'(17));
      check_result("b2b_second", 16'h0100, 16'h0200, 1'b0);
    end
    @(posedge clk); #1;
    check_eq("b2b_no_third", 32'(sif.busy), 32'(0));

    // reset mid-run aborts with no done
    @(negedge clk);
    sif.start = 1'b1; sif.a = 16'h00FF; sif.b = 16'h0001; sif.bin = 1'b0;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(sif.busy), 32'(0));
    check_eq("abort_done", 32'(sif.done), 32'(0));
    check_eq("abort_diff", 32'(sif.diff), 32'(0));
    check_eq("abort_bout", 32'(sif.bout), 32'(0));
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      dcount += int'(sif.done);
    end
    check_eq("abort_nodone", 32'(dcount), 32'(0));
    run_sub("after_abort", 16'h00FF, 16'h0001, 1'b0, d, bo);
    check_eq("after_abort_fe", 32'(d), 32'(16'h00FE));

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      run_sub("rand", ra, rb, rc, d, bo);
    end

    // adder round trip: (a + b + cin) - b - cin recovers a
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      run_sub("xchk", sum[15:0], rb, rc, d, bo);
      check_eq("xchk_recover", 32'(d), 32'(ra));
      check_eq("xchk_carry", 32'(bo), 32'(sum[16]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
